// File: rtl/decode_stage_nw.sv
// decode_stage_nw
//   N-wide RV32I decode stage between fetch and rename. Each cycle it can take
//   a group of up to DW instructions. It decodes every lane to register
//   indices, a sign-extended immediate, an ALU op class and an illegal flag.
//   The decoded group is registered and presented one cycle later. A skid
//   entry absorbs one cycle of downstream backpressure, so the stage runs at
//   full throughput.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   flush                  drop the held groups and any group offered this cycle
//   in_valid / in_ready    upstream group handshake
//   in_lane_valid [DW]     per-lane valid; only the run of ones from lane 0 counts
//   in_instr  [32*DW]      lane i = bits [32i+31:32i]
//   in_pc     [XLEN*DW]    lane i PC
//   out_valid / out_ready  downstream group handshake
//   out_lane_valid, out_pc, out_opcode, out_rs1, out_rs2, out_rd,
//   out_imm, out_alu_op, out_illegal   decoded per-lane fields, packed by lane
module decode_stage_nw #(
    parameter int DW   = 2,
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_lane_valid,
    input  logic [32*DW-1:0]  in_instr,
    input  logic [XLEN*DW-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_lane_valid,
    output logic [XLEN*DW-1:0] out_pc,
    output logic [7*DW-1:0]   out_opcode,
    output logic [5*DW-1:0]   out_rs1,
    output logic [5*DW-1:0]   out_rs2,
    output logic [5*DW-1:0]   out_rd,
    output logic [32*DW-1:0]  out_imm,
    output logic [3*DW-1:0]   out_alu_op,
    output logic [DW-1:0]     out_illegal
);

    typedef struct packed {
        logic            lane_valid;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [2:0]      alu_op;
        logic            illegal;
    } lane_t;

    typedef lane_t [DW-1:0] group_t;

    // An invalid lane decodes to all zeros, including pc and illegal.
    function automatic lane_t decode_lane(input logic v, input logic [31:0] instr,
                                          input logic [XLEN-1:0] pc);
        lane_t       d;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        d = '0;
        if (v) begin
            d.lane_valid = 1'b1;
            d.pc         = pc;
            d.opcode     = instr[6:0];
            case (instr[6:0])
                7'b0010011: begin d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i; d.alu_op = 3'd0; end
                7'b0110011: begin d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.rd = instr[11:7]; d.alu_op = 3'd1; end
                7'b0000011: begin d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i; d.alu_op = 3'd2; end
                7'b0100011: begin d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.imm = imm_s; d.alu_op = 3'd3; end
                7'b1100011: begin d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.imm = imm_b; d.alu_op = 3'd4; end
                7'b0110111: begin d.rd = instr[11:7]; d.imm = imm_u; d.alu_op = 3'd5; end
                7'b1100111: begin d.rs1 = instr[19:15]; d.rd = instr[11:7]; d.imm = imm_i; d.alu_op = 3'd6; end
                7'b1101111: begin d.rd = instr[11:7]; d.imm = imm_j; d.alu_op = 3'd7; end
                default:    d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    group_t dec_p0;
    logic   vld_p0;
    group_t main_p1, skid_p1;
    logic   main_vld_p1, skid_vld_p1;
    logic   accept, load, drain;

    // Stage 0: lane masking and combinational decode
    always_comb begin
        logic run;
        dec_p0 = '0;
        run    = 1'b1;
        // Lanes past the first cleared mask bit are forced invalid.
        for (int i = 0; i < DW; i++) begin
            run       = run & in_lane_valid[i];
            dec_p0[i] = decode_lane(run, in_instr[32*i +: 32], in_pc[XLEN*i +: XLEN]);
        end
        vld_p0 = in_lane_valid[0];
    end

    // in_ready comes from registered state only; out_ready never reaches it.
    assign in_ready = !skid_vld_p1 && !reset;
    assign accept   = in_valid && in_ready && !flush;
    // A group whose effective mask is empty is accepted and silently dropped.
    assign load     = accept && vld_p0;
    assign drain    = main_vld_p1 && out_ready;

    // Stage 1: main/skid group registers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (drain) begin
            if (skid_vld_p1) begin
                main_p1     <= skid_p1;
                main_vld_p1 <= 1'b1;
                skid_p1     <= '0;
                skid_vld_p1 <= 1'b0;
            end else if (load) begin
                main_p1     <= dec_p0;
                main_vld_p1 <= 1'b1;
            end else begin
                main_p1     <= '0;
                main_vld_p1 <= 1'b0;
            end
        end else if (!main_vld_p1) begin
            if (load) begin
                main_p1     <= dec_p0;
                main_vld_p1 <= 1'b1;
            end
        end else if (load) begin
            skid_p1     <= dec_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign out_valid = main_vld_p1;

    always_comb begin
        out_lane_valid = '0;
        out_pc         = '0;
        out_opcode     = '0;
        out_rs1        = '0;
        out_rs2        = '0;
        out_rd         = '0;
        out_imm        = '0;
        out_alu_op     = '0;
        out_illegal    = '0;
        for (int i = 0; i < DW; i++) begin
            out_lane_valid[i]        = main_p1[i].lane_valid;
            out_pc[XLEN*i +: XLEN]   = main_p1[i].pc;
            out_opcode[7*i +: 7]     = main_p1[i].opcode;
            out_rs1[5*i +: 5]        = main_p1[i].rs1;
            out_rs2[5*i +: 5]        = main_p1[i].rs2;
            out_rd[5*i +: 5]         = main_p1[i].rd;
            out_imm[32*i +: 32]      = main_p1[i].imm;
            out_alu_op[3*i +: 3]     = main_p1[i].alu_op;
            out_illegal[i]           = main_p1[i].illegal;
        end
    end

endmodule
